m_phy_tx_sm_ml: RTL and testbench

- Multi-lane, run-time-configurable successor to the single-lane Type-1 M-PHY-TX state machine.
- One shared FSM (UNPOWERED/DISABLED/HIBERN8/SLEEP/STALL/PWM_BURST/LINE_CFG/HS_BURST/LINE_RESET) controls NUM_LANES lanes.
- Line conditions are qualified across a lane-enable mask. Timing thresholds come from configuration ports instead of elaboration constants.
- Adds lane-skew error detection, a defined busy output and a full state report. Sits between the PHY-adapter control SAP and the per-lane TX drivers.

---
 rtl/m_phy_tx_sm_ml.sv | 160 ++++++++++++++++
 tb/tb_m_phy_tx_sm_ml.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_phy_tx_sm_ml.sv
// m_phy_tx_sm_ml: shared multi-lane M-PHY TX state machine with lane-skew detection
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   i_power_on                leave UNPOWERED
//   i_phy_reset / i_sap_reset force DISABLED / LINE_RESET (sap also clears o_lane_err)
//   i_rct, i_*_2_*            return-to-HIBERN8 and burst exit requests
//   i_lane_en, i_line_state   lane mask and per-lane line state (N=0,P=1,Q=2,Z=3)
//   i_cfg_t_*                 quasi-static timing thresholds
//   o_phy_state               state code, one cycle late
//   o_busy, o_lane_err        registered busy flag, sticky skew error
module m_phy_tx_sm_ml #(
   parameter int NUM_LANES        = 4,
   parameter int CNT_W            = 16,
   parameter int RESET_COMPLETION = 16
) (
   input  logic                   i_clk,
   input  logic                   i_reset_n,
   input  logic                   i_power_on,
   input  logic                   i_phy_reset,
   input  logic                   i_sap_reset,
   input  logic                   i_rct,
   input  logic                   i_pwm_2_sleep,
   input  logic                   i_pwm_2_line_cfg,
   input  logic                   i_line_cfg_2_sleep,
   input  logic                   i_line_cfg_2_stall,
   input  logic                   i_hs_2_stall,
   input  logic                   i_hs_2_line_cfg,
   input  logic [NUM_LANES-1:0]   i_lane_en,
   input  logic [2*NUM_LANES-1:0] i_line_state,
   input  logic [CNT_W-1:0]       i_cfg_t_active,
   input  logic [CNT_W-1:0]       i_cfg_t_line_reset,
   input  logic [CNT_W-1:0]       i_cfg_t_hs_prepare,
   input  logic [CNT_W-1:0]       i_cfg_t_pwm_prepare,
   input  logic [CNT_W-1:0]       i_cfg_t_skew,
   output logic [3:0]             o_phy_state,
   output logic                   o_busy,
   output logic                   o_lane_err
);
   typedef enum logic [3:0] {
      S_UNPOWERED  = 4'd0,
      S_DISABLED   = 4'd1,
      S_HIBERN8    = 4'd2,
      S_SLEEP      = 4'd3,
      S_STALL      = 4'd4,
      S_PWM_BURST  = 4'd5,
      S_LINE_CFG   = 4'd6,
      S_HS_BURST   = 4'd7,
      S_LINE_RESET = 4'd8
   } state_t;
   localparam logic [CNT_W:0]   ONE = {{CNT_W{1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] C1  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W:0]   RC  = (CNT_W+1)'(RESET_COMPLETION);
   state_t           r_state, w_nxt_state;
   logic [CNT_W-1:0] r_count, r_skew, w_nxt_count, w_nxt_skew, w_cnt_inc, w_skew_inc;
   logic [3:0]       w_seen;
   logic             w_all_n, w_all_p, w_any_z, w_mis, w_skew_st, w_trip, w_rc_done;
   logic             w_nxt_err, w_nxt_busy;
   // count+1 >= max(thr,1), evaluated one bit wider so the saturated count cannot wrap
   function automatic logic f_reach(input logic [CNT_W-1:0] cnt, input logic [CNT_W-1:0] thr);
      return ({1'b0, cnt} + ONE) >= ((thr == '0) ? ONE : {1'b0, thr});
   endfunction
   // one-hot set of line values seen on enabled lanes; every aggregate derives from it
   always_comb begin
      w_seen = '0;
      for (int i = 0; i < NUM_LANES; i++)
         if (i_lane_en[i]) w_seen[i_line_state[2*i +: 2]] = 1'b1;
   end
   assign w_all_n    = (w_seen == 4'b0001);
   assign w_all_p    = (w_seen == 4'b0010);
   assign w_any_z    = w_seen[3];
   assign w_mis      = (w_seen & (w_seen - 4'd1)) != 4'd0;
   assign w_cnt_inc  = &r_count ? r_count : r_count + C1;
   assign w_skew_inc = &r_skew ? r_skew : r_skew + C1;
   assign w_skew_st  = r_state inside {S_HIBERN8, S_SLEEP, S_STALL, S_LINE_RESET};
   assign w_trip     = w_skew_st && w_mis && f_reach(r_skew, i_cfg_t_skew);
   assign w_rc_done  = ({1'b0, r_count} + ONE) >= RC;
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_count = r_count;
      w_nxt_err   = o_lane_err;
      w_nxt_skew  = (w_skew_st && w_mis) ? w_skew_inc : '0;
      if (i_phy_reset) begin
         w_nxt_state = S_DISABLED;
         w_nxt_count = '0;
         w_nxt_skew  = '0;
      end else if (i_sap_reset) begin
         w_nxt_state = S_LINE_RESET;
         w_nxt_count = '0;
         w_nxt_skew  = '0;
         w_nxt_err   = 1'b0;
      end else if (w_trip) begin
         w_nxt_state = S_HIBERN8;
         w_nxt_count = '0;
         w_nxt_skew  = '0;
         w_nxt_err   = 1'b1;
      end else begin
         case (r_state)
            S_UNPOWERED: if (i_power_on) w_nxt_state = S_DISABLED;
            S_DISABLED: begin
               w_nxt_state = w_rc_done ? S_HIBERN8 : S_DISABLED;
               w_nxt_count = w_rc_done ? '0 : w_cnt_inc;
            end
            S_HIBERN8: begin
               if (w_any_z) w_nxt_count = '0;
               else if (w_all_n && f_reach(r_count, i_cfg_t_active)) begin
                  w_nxt_state = S_STALL;
                  w_nxt_count = '0;
               end else if (w_all_n) w_nxt_count = w_cnt_inc;
               else if (!w_mis) begin
                  w_nxt_state = S_SLEEP;
                  w_nxt_count = '0;
               end
            end
            S_SLEEP, S_STALL: begin
               if (i_rct) begin
                  w_nxt_state = S_HIBERN8;
                  w_nxt_count = '0;
               end else if (w_all_n) w_nxt_count = '0;
               else if (w_all_p && f_reach(r_count, (r_state == S_SLEEP) ? i_cfg_t_pwm_prepare : i_cfg_t_hs_prepare)) begin
                  w_nxt_state = (r_state == S_SLEEP) ? S_PWM_BURST : S_HS_BURST;
                  w_nxt_count = '0;
               end else if (w_all_p) w_nxt_count = w_cnt_inc;
            end
            S_LINE_RESET: begin
               if (w_all_n && f_reach(r_count, i_cfg_t_line_reset)) begin
                  w_nxt_state = S_SLEEP;
                  w_nxt_count = '0;
               end else if (w_all_p) w_nxt_count = w_cnt_inc;
            end
            S_PWM_BURST: w_nxt_state = i_pwm_2_sleep ? S_SLEEP : i_pwm_2_line_cfg ? S_LINE_CFG : S_PWM_BURST;
            S_LINE_CFG: w_nxt_state = i_rct ? S_HIBERN8 : i_line_cfg_2_sleep ? S_SLEEP :
                                      i_line_cfg_2_stall ? S_STALL : S_LINE_CFG;
            S_HS_BURST: w_nxt_state = i_hs_2_stall ? S_STALL : i_hs_2_line_cfg ? S_LINE_CFG : S_HS_BURST;
            default: begin
               w_nxt_state = S_UNPOWERED;
               w_nxt_count = '0;
            end
         endcase
      end
   end
   // busy reflects the state being entered, so it lines up with r_state rather than o_phy_state
   assign w_nxt_busy = (w_nxt_state inside {S_DISABLED, S_LINE_RESET, S_PWM_BURST, S_LINE_CFG, S_HS_BURST}) ||
                       ((w_nxt_state inside {S_SLEEP, S_STALL}) && (w_nxt_count != '0));
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state     <= S_UNPOWERED;
         r_count     <= '0;
         r_skew      <= '0;
         o_phy_state <= 4'd0;
         o_busy      <= 1'b0;
         o_lane_err  <= 1'b0;
      end else begin
         r_state     <= w_nxt_state;
         r_count     <= w_nxt_count;
         r_skew      <= w_nxt_skew;
         o_phy_state <= r_state;
         o_busy      <= w_nxt_busy;
         o_lane_err  <= w_nxt_err;
      end
   end
endmodule

// File: tb/tb_m_phy_tx_sm_ml.sv
// tb_m_phy_tx_sm_ml: directed and randomized check of m_phy_tx_sm_ml against a behavioural model
module tb_m_phy_tx_sm_ml;
   localparam int NL   = 4;
   localparam int CW   = 16;
   localparam int RC   = 16;
   localparam int CMAX = (1 << CW) - 1;
   logic clk = 1'b0, reset_n = 1'b0, power_on = 1'b0, phy_reset = 1'b0, sap_reset = 1'b0, rct = 1'b0;
   logic pwm_2_sleep = 1'b0, pwm_2_line_cfg = 1'b0, line_cfg_2_sleep = 1'b0, line_cfg_2_stall = 1'b0;
   logic hs_2_stall = 1'b0, hs_2_line_cfg = 1'b0;
   logic [NL-1:0]   lane_en = '0;
   logic [2*NL-1:0] line_state = '0;
   logic [CW-1:0]   t_act = 16'd5, t_lr = 16'd2, t_hs = 16'd3, t_pwm = 16'd2, t_skew = 16'd10;
   logic [3:0]      phy_state;
   logic            busy, lane_err;
   int n_chk = 0, n_fail = 0;
   int ms, mc, msk, mps;
   bit merr, mbusy;
   always #5 clk = ~clk;
   m_phy_tx_sm_ml #(.NUM_LANES(NL), .CNT_W(CW), .RESET_COMPLETION(RC)) dut (
      .i_clk(clk), .i_reset_n(reset_n), .i_power_on(power_on), .i_phy_reset(phy_reset),
      .i_sap_reset(sap_reset), .i_rct(rct), .i_pwm_2_sleep(pwm_2_sleep), .i_pwm_2_line_cfg(pwm_2_line_cfg),
      .i_line_cfg_2_sleep(line_cfg_2_sleep), .i_line_cfg_2_stall(line_cfg_2_stall),
      .i_hs_2_stall(hs_2_stall), .i_hs_2_line_cfg(hs_2_line_cfg), .i_lane_en(lane_en),
      .i_line_state(line_state), .i_cfg_t_active(t_act), .i_cfg_t_line_reset(t_lr),
      .i_cfg_t_hs_prepare(t_hs), .i_cfg_t_pwm_prepare(t_pwm), .i_cfg_t_skew(t_skew),
      .o_phy_state(phy_state), .o_busy(busy), .o_lane_err(lane_err)
   );
   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask
   function automatic int tq(input int t);
      return (t < 1) ? 1 : t;
   endfunction
   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction
   task automatic m_reset;
      ms = 0; mc = 0; msk = 0; mps = 0; merr = 0; mbusy = 0;
   endtask
   // line aggregates from the list of values on enabled lanes
   task automatic agg(output bit an, output bit ap, output bit az, output bit mm);
      int q[$];
      for (int i = 0; i < NL; i++)
         if (lane_en[i]) q.push_back(int'(line_state[2*i +: 2]));
      an = q.size() > 0;
      ap = q.size() > 0;
      az = 0;
      mm = 0;
      foreach (q[k]) begin
         if (q[k] != 0) an = 0;
         if (q[k] != 1) ap = 0;
         if (q[k] == 3) az = 1;
         if (q[k] != q[0]) mm = 1;
      end
   endtask
   task automatic m_step;
      bit an, ap, az, mm, sk, trip;
      int ns, nc, nsk;
      agg(an, ap, az, mm);
      sk   = ms inside {2, 3, 4, 8};
      trip = sk && mm && (msk + 1 >= tq(int'(t_skew)));
      ns   = ms;
      nc   = mc;
      nsk  = (sk && mm) ? sat(msk + 1) : 0;
      if (phy_reset) begin
         ns = 1; nc = 0; nsk = 0;
      end else if (sap_reset) begin
         ns = 8; nc = 0; nsk = 0; merr = 0;
      end else if (trip) begin
         ns = 2; nc = 0; nsk = 0; merr = 1;
      end else begin
         case (ms)
            0: if (power_on) ns = 1;
            1: if (mc + 1 >= RC) ns = 2; else nc = sat(mc + 1);
            2: if (az) nc = 0;
               else if (an) begin
                  if (mc + 1 >= tq(int'(t_act))) ns = 4; else nc = sat(mc + 1);
               end else if (!mm) ns = 3;
            3, 4: if (rct) ns = 2;
               else if (an) nc = 0;
               else if (ap) begin
                  if (mc + 1 >= tq(ms == 3 ? int'(t_pwm) : int'(t_hs))) ns = (ms == 3) ? 5 : 7;
                  else nc = sat(mc + 1);
               end
            5: if (pwm_2_sleep) ns = 3; else if (pwm_2_line_cfg) ns = 6;
            6: if (rct) ns = 2; else if (line_cfg_2_sleep) ns = 3; else if (line_cfg_2_stall) ns = 4;
            7: if (hs_2_stall) ns = 4; else if (hs_2_line_cfg) ns = 6;
            8: if (an && mc + 1 >= tq(int'(t_lr))) ns = 3; else if (ap) nc = sat(mc + 1);
            default: ns = 0;
         endcase
      end
      if (ns != ms) nc = 0;
      mps   = ms;
      ms    = ns;
      mc    = nc;
      msk   = nsk;
      mbusy = (ns inside {1, 5, 6, 7, 8}) || ((ns inside {3, 4}) && nc != 0);
   endtask
   task automatic cyc;
      @(posedge clk);
      m_step();
      @(negedge clk);
      chk("phy_state", int'(phy_state), mps);
      chk("busy", int'(busy), int'(mbusy));
      chk("lane_err", int'(lane_err), int'(merr));
   endtask
   task automatic run_to(input int target, input int lim);
      int k = 0;
      while (ms != target && k < lim) begin
         cyc();
         k++;
      end
      if (ms != target) chk("run_to_timeout", ms, target);
   endtask
   task automatic async_reset;
      #2 reset_n = 1'b0;
      m_reset();
      #1;
      chk("arst_phy_state", int'(phy_state), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_lane_err", int'(lane_err), 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask
   initial begin
      int mode = 0, zl = 0, v;
      logic [2*NL-1:0] ls;
      m_reset();
      lane_en    = 4'hF;
      line_state = 8'hFF;
      #1;
      chk("rst_phy_state", int'(phy_state), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_lane_err", int'(lane_err), 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      // power-up through DISABLED into HIBERN8
      power_on = 1'b1;
      cyc();
      power_on = 1'b0;
      chk("t1_dis_busy", int'(busy), 1);
      repeat (15) cyc();
      chk("t1_still_dis", int'(phy_state), 1);
      cyc();
      chk("t1_hib_busy", int'(busy), 0);
      cyc();
      chk("t1_hib", int'(phy_state), 2);
      // HIBERN8 -> STALL with a Z restart
      line_state = 8'h00;
      repeat (2) cyc();
      line_state = 8'h30;
      cyc();
      line_state = 8'h00;
      repeat (5) cyc();
      chk("t2_pre_stall", int'(phy_state), 2);
      cyc();
      chk("t2_stall", int'(phy_state), 4);
      // STALL -> HS_BURST -> STALL
      line_state = 8'h55;
      repeat (3) cyc();
      chk("t3_hs_busy", int'(busy), 1);
      chk("t3_pre_hs", int'(phy_state), 4);
      cyc();
      chk("t3_hs", int'(phy_state), 7);
      hs_2_stall = 1'b1;
      cyc();
      hs_2_stall = 1'b0;
      chk("t3_stall_busy", int'(busy), 0);
      // masked lanes: SLEEP -> PWM_BURST ignoring disabled N lanes
      rct        = 1'b1;
      lane_en    = 4'b0011;
      line_state = 8'h05;
      cyc();
      rct = 1'b0;
      cyc();
      cyc();
      chk("t4_sleep_busy", int'(busy), 1);
      cyc();
      chk("t4_pwm_busy", int'(busy), 1);
      chk("t4_pre_pwm", int'(phy_state), 3);
      cyc();
      chk("t4_pwm", int'(phy_state), 5);
      chk("t4_no_err", int'(lane_err), 0);
      // skew trip in SLEEP, cleared by sap_reset
      pwm_2_sleep = 1'b1;
      line_state  = 8'h01;
      t_skew      = 16'd4;
      cyc();
      pwm_2_sleep = 1'b0;
      repeat (3) cyc();
      chk("t5_no_err_yet", int'(lane_err), 0);
      cyc();
      chk("t5_err", int'(lane_err), 1);
      cyc();
      chk("t5_hib", int'(phy_state), 2);
      sap_reset = 1'b1;
      cyc();
      sap_reset = 1'b0;
      chk("t5_err_clr", int'(lane_err), 0);
      chk("t5_lr_busy", int'(busy), 1);
      // LINE_RESET -> SLEEP -> PWM -> LINE_CFG -> STALL -> HS, then resets
      lane_en    = 4'hF;
      line_state = 8'h55;
      t_skew     = 16'd10;
      repeat (2) cyc();
      line_state = 8'h00;
      cyc();
      chk("t6_lr_exit_busy", int'(busy), 0);
      line_state = 8'h55;
      run_to(5, 20);
      pwm_2_line_cfg = 1'b1;
      cyc();
      pwm_2_line_cfg   = 1'b0;
      line_cfg_2_stall = 1'b1;
      cyc();
      line_cfg_2_stall = 1'b0;
      run_to(7, 20);
      cyc();
      chk("t6_hs", int'(phy_state), 7);
      chk("t6_hs_busy", int'(busy), 1);
      phy_reset = 1'b1;
      sap_reset = 1'b1;
      cyc();
      phy_reset = 1'b0;
      sap_reset = 1'b0;
      chk("t6_dis_busy", int'(busy), 1);
      cyc();
      chk("t6_dis", int'(phy_state), 1);
      run_to(5, 60);
      pwm_2_line_cfg = 1'b1;
      cyc();
      pwm_2_line_cfg   = 1'b0;
      line_cfg_2_stall = 1'b1;
      cyc();
      line_cfg_2_stall = 1'b0;
      run_to(7, 20);
      async_reset();
      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if (n % 300 == 0) begin
            t_act  = CW'($urandom_range(6, 0));
            t_lr   = CW'($urandom_range(6, 0));
            t_hs   = CW'($urandom_range(6, 0));
            t_pwm  = CW'($urandom_range(6, 0));
            t_skew = CW'($urandom_range(8, 0));
         end
         power_on         = ($urandom % 2) == 0;
         phy_reset        = ($urandom % 80) == 0;
         sap_reset        = ($urandom % 60) == 0;
         rct              = ($urandom % 12) == 0;
         pwm_2_sleep      = ($urandom % 6) == 0;
         pwm_2_line_cfg   = ($urandom % 6) == 0;
         line_cfg_2_sleep = ($urandom % 6) == 0;
         line_cfg_2_stall = ($urandom % 6) == 0;
         hs_2_stall       = ($urandom % 6) == 0;
         hs_2_line_cfg    = ($urandom % 6) == 0;
         if ($urandom % 40 == 0) lane_en = NL'($urandom);
         if ($urandom % 6 == 0) begin
            mode = int'($urandom % 6);
            zl   = int'($urandom % NL);
         end
         ls = '0;
         for (int i = 0; i < NL; i++) begin
            case (mode)
               0: v = 0;
               1: v = 1;
               2: v = 2;
               3: v = (i == zl) ? 3 : 0;
               4: v = int'($urandom % 4);
               default: v = ($urandom % 8 == 0) ? 0 : 1;
            endcase
            ls[2*i +: 2] = 2'(v);
         end
         line_state = ls;
         cyc();
      end
      async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
